// File: rtl/canny_hysteresis_threshold.sv
// rtl/canny_hysteresis_threshold.sv - Canny double-threshold classification and hysteresis over a 3x3 class window
module canny_hysteresis_threshold #(
  parameter int MAG_WIDTH = 11,
  parameter int IMG_WIDTH = 640,
  parameter int CNT_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst_s,
  input  logic                 pre_frame_vsync,
  input  logic                 pre_frame_href,
  input  logic                 pre_frame_clken,
  input  logic [MAG_WIDTH-1:0] mag,
  input  logic [MAG_WIDTH-1:0] thr_high,
  input  logic [MAG_WIDTH-1:0] thr_low,
  input  logic                 cfg_connect8,
  output logic                 post_frame_vsync,
  output logic                 post_frame_href,
  output logic                 post_frame_clken,
  output logic                 canny_out,
  output logic [CNT_WIDTH-1:0] edge_count,
  output logic                 edge_count_valid,
  output logic                 cfg_err
);

  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH);
  localparam logic [1:0] C_NONE = 2'd0, C_WEAK = 2'd1, C_STRONG = 2'd2;

  logic                 vsync_q, href_q, in_frame, connect8_q;
  logic [MAG_WIDTH-1:0] thr_high_q, thr_low_q;
  logic [1:0]           row_cnt;
  logic [CW-1:0]        col_cnt;

  logic                 frame_start, active, vs0, hs0, ck0, href_fall, conn0;
  logic [MAG_WIDTH-1:0] eff_high, eff_low;
  logic [1:0]           row0, cls0;
  logic [CW-1:0]        col0;

  // Strobes are ignored until a genuine vsync rise, so a reset inside a frame stays silent.
  always_comb begin
    frame_start = pre_frame_vsync & ~vsync_q;
    active      = frame_start | in_frame;
    vs0         = pre_frame_vsync & active;
    hs0         = pre_frame_href & active;
    ck0         = pre_frame_clken & active;
    href_fall   = href_q & ~hs0;
    eff_high    = frame_start ? thr_high : thr_high_q;
    eff_low     = frame_start ? ((thr_low > thr_high) ? thr_high : thr_low) : thr_low_q;
    conn0       = frame_start ? cfg_connect8 : connect8_q;
    row0        = frame_start ? 2'd0 : row_cnt;
    col0        = frame_start ? '0 : col_cnt;
    if (mag >= eff_high)     cls0 = C_STRONG;
    else if (mag >= eff_low) cls0 = C_WEAK;
    else                     cls0 = C_NONE;
  end

  // vsync_q resets high so a vsync already asserted at reset release is not a frame start.
  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      vsync_q    <= 1'b1;
      href_q     <= 1'b0;
      in_frame   <= 1'b0;
      thr_high_q <= '0;
      thr_low_q  <= '0;
      connect8_q <= 1'b0;
      cfg_err    <= 1'b0;
      row_cnt    <= 2'd0;
      col_cnt    <= '0;
    end else begin
      vsync_q  <= pre_frame_vsync;
      href_q   <= hs0;
      in_frame <= vs0;
      if (frame_start) begin
        thr_high_q <= eff_high;
        thr_low_q  <= eff_low;
        connect8_q <= cfg_connect8;
        cfg_err    <= thr_low > thr_high;
      end
      if (frame_start)                        row_cnt <= 2'd0;
      else if (href_fall && row_cnt != 2'd2)  row_cnt <= row_cnt + 2'd1;
      if (href_fall)                          col_cnt <= '0;
      else if (ck0 && col0 != COL_MAX)        col_cnt <= col0 + 1'b1;
      else                                    col_cnt <= col0;
    end
  end

  logic          vs1, hs1, ck1, conn1;
  logic [1:0]    cls1, row1;
  logic [CW-1:0] col1;

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      {vs1, hs1, ck1, conn1} <= 4'b0;
      cls1 <= C_NONE;
      row1 <= 2'd0;
      col1 <= '0;
    end else begin
      {vs1, hs1, ck1, conn1} <= {vs0, hs0, ck0, conn0};
      cls1 <= cls0;
      row1 <= row0;
      col1 <= col0;
    end
  end

  logic [1:0] ram1 [IMG_WIDTH];
  logic [1:0] ram2 [IMG_WIDTH];
  logic       in1;
  logic [1:0] rd1, rd2;

  always_comb begin
    in1 = (col1 != COL_MAX);
    rd1 = in1 ? ram1[col1[AW-1:0]] : C_NONE;
    rd2 = in1 ? ram2[col1[AW-1:0]] : C_NONE;
  end

  always_ff @(posedge clk) begin
    if (ck1 && in1) begin
      ram1[col1[AW-1:0]] <= cls1;
      ram2[col1[AW-1:0]] <= ram1[col1[AW-1:0]];
    end
  end

  // Window rows: top = r-2, mid = r-1, bot = r; within a row [1:0] is column c, [5:4] is c-2.
  logic [5:0] top_w, mid_w, bot_w;
  logic       vs2, hs2, ck2, conn2, in2, r0_2, r1_2, c0_2, c1_2;

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      top_w <= '0;
      mid_w <= '0;
      bot_w <= '0;
      {vs2, hs2, ck2, conn2, in2, r0_2, r1_2, c0_2, c1_2} <= 9'b0;
    end else begin
      if (ck1) begin
        top_w <= {top_w[3:0], rd2};
        mid_w <= {mid_w[3:0], rd1};
        bot_w <= {bot_w[3:0], cls1};
      end
      {vs2, hs2, ck2, conn2, in2} <= {vs1, hs1, ck1, conn1, in1};
      r0_2 <= (row1 == 2'd0);
      r1_2 <= (row1 == 2'd1);
      c0_2 <= (col1 == CW'(0));
      c1_2 <= (col1 == CW'(1));
    end
  end

  logic top_ok, left_ok, orth, diag, centre_s, centre_w, edge_d;

  always_comb begin
    top_ok   = ~r1_2;
    left_ok  = ~c1_2;
    centre_s = (mid_w[3:2] == C_STRONG);
    centre_w = (mid_w[3:2] == C_WEAK);
    orth     = (top_ok & (top_w[3:2] == C_STRONG)) | (bot_w[3:2] == C_STRONG) |
               (left_ok & (mid_w[5:4] == C_STRONG)) | (mid_w[1:0] == C_STRONG);
    diag     = (top_ok & left_ok & (top_w[5:4] == C_STRONG)) | (top_ok & (top_w[1:0] == C_STRONG)) |
               (left_ok & (bot_w[5:4] == C_STRONG)) | (bot_w[1:0] == C_STRONG);
    edge_d   = ck2 & in2 & ~r0_2 & ~c0_2 & (centre_s | (centre_w & (orth | (conn2 & diag))));
  end

  logic                 post_vs_q, vs_fall, hit;
  logic [CNT_WIDTH-1:0] cnt, cnt_inc;

  always_comb begin
    vs_fall = post_vs_q & ~post_frame_vsync;
    hit     = post_frame_clken & canny_out;
    cnt_inc = (hit && cnt != '1) ? cnt + 1'b1 : cnt;
  end

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      {post_frame_vsync, post_frame_href, post_frame_clken, canny_out} <= 4'b0;
      post_vs_q        <= 1'b0;
      edge_count_valid <= 1'b0;
      edge_count       <= '0;
      cnt              <= '0;
    end else begin
      {post_frame_vsync, post_frame_href, post_frame_clken, canny_out} <= {vs2, hs2, ck2, edge_d};
      post_vs_q        <= post_frame_vsync;
      edge_count_valid <= vs_fall;
      if (vs_fall) begin
        edge_count <= cnt_inc;
        cnt        <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_canny_hysteresis_threshold.sv
// tb/tb_canny_hysteresis_threshold.sv - randomized and directed bench for canny_hysteresis_threshold
module tb_canny_hysteresis_threshold;
  localparam int MW = 11, IW = 8, CNTW = 5;
  localparam int CMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst_s, pre_frame_vsync, pre_frame_href, pre_frame_clken, cfg_connect8;
  logic [MW-1:0] mag, thr_high, thr_low;
  logic post_frame_vsync, post_frame_href, post_frame_clken, canny_out, edge_count_valid, cfg_err;
  logic [CNTW-1:0] edge_count;

  always #5 clk = ~clk;

  canny_hysteresis_threshold #(.MAG_WIDTH(MW), .IMG_WIDTH(IW), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst_s(rst_s),
    .pre_frame_vsync(pre_frame_vsync), .pre_frame_href(pre_frame_href), .pre_frame_clken(pre_frame_clken),
    .mag(mag), .thr_high(thr_high), .thr_low(thr_low), .cfg_connect8(cfg_connect8),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href), .post_frame_clken(post_frame_clken),
    .canny_out(canny_out), .edge_count(edge_count), .edge_count_valid(edge_count_valid), .cfg_err(cfg_err)
  );

  int n_cmp = 0, n_fail = 0;
  int img [0:7][0:11];
  bit got_q[$];
  bit mon_en = 1'b0;
  int hist_n = 0, n_valid = 0, ec_seen = -1;
  logic hv[3], hh[3], hc[3], pv[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 12; c++) img[r][c] = v;
  endtask

  function automatic int cls(input int m, input int th, input int tl);
    if (m >= th) return 2;
    if (tl <= th && m >= tl) return 1;
    return 0;
  endfunction

  // Output for the input strobe at (r,c) judges the pixel at (r-1,c-1) inside the image.
  function automatic bit model_edge(input int r, input int c, input int th, input int tl, input bit conn);
    int cr, cc, k;
    if (r == 0 || c == 0 || c >= IW) return 1'b0;
    cr = r - 1;
    cc = c - 1;
    k = cls(img[cr][cc], th, tl);
    if (k == 2) return 1'b1;
    if (k == 0) return 1'b0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr == 0 && dc == 0) continue;
        if (!conn && dr != 0 && dc != 0) continue;
        if (cr + dr < 0 || cc + dc < 0) continue;
        if (cls(img[cr+dr][cc+dc], th, tl) == 2) return 1'b1;
      end
    return 1'b0;
  endfunction

  initial forever begin
    @(negedge clk);
    if (!mon_en) begin
      hist_n = 0;
    end else begin
      if (hist_n >= 3) begin
        check("post_vsync_delay", post_frame_vsync, hv[2]);
        check("post_href_delay", post_frame_href, hh[2]);
        check("post_clken_delay", post_frame_clken, hc[2]);
        check("valid_timing", edge_count_valid, pv[1] & ~pv[0]);
      end
      if (post_frame_clken) got_q.push_back(canny_out);
      if (edge_count_valid) begin
        n_valid++;
        ec_seen = int'(edge_count);
      end
      hv[2] = hv[1]; hv[1] = hv[0]; hv[0] = pre_frame_vsync;
      hh[2] = hh[1]; hh[1] = hh[0]; hh[0] = pre_frame_href;
      hc[2] = hc[1]; hc[1] = hc[0]; hc[0] = pre_frame_clken;
      pv[1] = pv[0]; pv[0] = post_frame_vsync;
      hist_n++;
    end
  end

  task automatic run_frame(input int rows, input int cols, input bit conn, input int th, input int tl,
                           input int gap, output int dut_cnt);
    bit exp_q[$];
    int exp_cnt, g;
    got_q.delete();
    n_valid = 0;
    ec_seen = -1;
    thr_high = MW'(th);
    thr_low = MW'(tl);
    cfg_connect8 = conn;
    pre_frame_vsync = 1'b1;
    tick();
    check("cfg_err", cfg_err, (tl > th) ? 1 : 0);
    thr_high = MW'($urandom);
    thr_low = MW'($urandom);
    cfg_connect8 = ~conn;
    tick();
    for (int r = 0; r < rows; r++) begin
      pre_frame_href = 1'b1;
      for (int c = 0; c < cols; c++) begin
        mag = MW'(img[r][c]);
        pre_frame_clken = 1'b1;
        tick();
        pre_frame_clken = 1'b0;
        mag = MW'($urandom);
        g = (gap == 1) ? 2 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (g) tick();
      end
      pre_frame_href = 1'b0;
      repeat (3) tick();
    end
    pre_frame_vsync = 1'b0;
    repeat (8) tick();
    exp_cnt = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        exp_q.push_back(model_edge(r, c, th, tl, conn));
        exp_cnt += int'(exp_q[$]);
      end
    check("strobe_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("pix_r%0d_c%0d", i / cols, i % cols), got_q[i], exp_q[i]);
    if (exp_cnt > CMAX) exp_cnt = CMAX;
    check("valid_pulses", n_valid, 1);
    check("edge_count", ec_seen, exp_cnt);
    dut_cnt = ec_seen;
  endtask

  initial begin
    int cnt, th, tl, rr, cc, gp;
    bit cb, quiet;
    rst_s = 1'b0;
    {pre_frame_vsync, pre_frame_href, pre_frame_clken, cfg_connect8} = 4'b0;
    mag = '0;
    thr_high = '0;
    thr_low = '0;
    repeat (3) tick();
    check("rst_post_vsync", post_frame_vsync, 0);
    check("rst_post_href", post_frame_href, 0);
    check("rst_post_clken", post_frame_clken, 0);
    check("rst_canny_out", canny_out, 0);
    check("rst_edge_count", edge_count, 0);
    check("rst_valid", edge_count_valid, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst_s = 1'b1;
    tick();
    mon_en = 1'b1;
    repeat (2) tick();

    fill(200);
    run_frame(4, 8, 1'b1, 100, 50, 0, cnt);
    check("all200_count", cnt, 21);

    fill(0); img[1][3] = 150; img[2][4] = 60;
    run_frame(4, 8, 1'b1, 100, 50, 0, cnt);
    check("diag_conn8", cnt, 2);
    run_frame(4, 8, 1'b0, 100, 50, 0, cnt);
    check("diag_conn4", cnt, 1);

    fill(0); img[1][3] = 60;
    run_frame(4, 8, 1'b1, 100, 50, 0, cnt);
    check("weak_alone", cnt, 0);
    img[1][3] = 100;
    run_frame(4, 8, 1'b1, 100, 50, 0, cnt);
    check("high_inclusive", cnt, 1);
    img[1][3] = 49;
    run_frame(4, 8, 1'b1, 100, 50, 0, cnt);
    check("below_low", cnt, 0);

    fill(0); img[1][3] = 130; img[1][4] = 90;
    run_frame(4, 8, 1'b1, 100, 120, 0, cnt);
    check("cfg_err_frame", cnt, 1);

    fill(200);
    run_frame(4, 8, 1'b1, 100, 50, 1, cnt);
    check("gapped_count", cnt, 21);
    run_frame(4, 10, 1'b1, 100, 50, 0, cnt);
    check("overlong_count", cnt, 21);
    run_frame(6, 8, 1'b0, 100, 50, 2, cnt);
    check("saturate_count", cnt, CMAX);

    for (int f = 0; f < 8; f++) begin
      th = int'($urandom_range(20, 1500));
      tl = int'($urandom_range(0, 1600));
      rr = int'($urandom_range(2, 6));
      cc = int'($urandom_range(2, 10));
      cb = 1'($urandom_range(0, 1));
      gp = int'($urandom_range(0, 2));
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 12; c++)
          case ($urandom_range(0, 5))
            0: img[r][c] = 0;
            1: img[r][c] = (tl > 0) ? tl - 1 : 0;
            2: img[r][c] = tl;
            3: img[r][c] = th - 1;
            4: img[r][c] = th;
            default: img[r][c] = int'($urandom_range(0, 2047));
          endcase
      run_frame(rr, cc, cb, th, tl, gp, cnt);
    end

    mon_en = 1'b0;
    tick();
    thr_high = MW'(100);
    thr_low = MW'(120);
    pre_frame_vsync = 1'b1;
    tick();
    pre_frame_href = 1'b1;
    mag = MW'(200);
    repeat (4) begin
      pre_frame_clken = 1'b1;
      tick();
      pre_frame_clken = 1'b0;
      tick();
    end
    rst_s = 1'b0;
    #1;
    check("midrst_post_vsync", post_frame_vsync, 0);
    check("midrst_post_href", post_frame_href, 0);
    check("midrst_post_clken", post_frame_clken, 0);
    check("midrst_canny_out", canny_out, 0);
    check("midrst_edge_count", edge_count, 0);
    check("midrst_valid", edge_count_valid, 0);
    check("midrst_cfg_err", cfg_err, 0);
    tick();
    rst_s = 1'b1;
    quiet = 1'b0;
    repeat (12) begin
      pre_frame_clken = ~pre_frame_clken;
      tick();
      quiet |= post_frame_vsync | post_frame_href | post_frame_clken | canny_out | edge_count_valid;
    end
    pre_frame_clken = 1'b0;
    pre_frame_href = 1'b0;
    repeat (2) tick();
    pre_frame_vsync = 1'b0;
    repeat (8) begin
      tick();
      quiet |= post_frame_vsync | post_frame_href | post_frame_clken | canny_out | edge_count_valid;
    end
    check("midrst_quiet", quiet, 0);
    mon_en = 1'b1;
    repeat (2) tick();
    fill(200);
    run_frame(4, 8, 1'b1, 100, 50, 0, cnt);
    check("post_rst_count", cnt, 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
